// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial half-adder based adder controller.
//   STATE_W  : width of the controller state register
//   IDLE..DONE : state encodings
//   state_e  : enumerated controller state
//   cnt_w()  : width of the bit counter for a given operand width
package serial_add_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] PASS1 = 2'd1;
  localparam logic [STATE_W-1:0] PASS2 = 2'd2;
  localparam logic [STATE_W-1:0] DONE  = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = IDLE,
    ST_PASS1 = PASS1,
    ST_PASS2 = PASS2,
    ST_DONE  = DONE
  } state_e;

  // One extra bit so the counter can hold WIDTH itself after the last increment.
  function automatic int cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_ha_add_ctrl_ha.sv
// Single-bit half adder cell, the only arithmetic element of the serial adder.
//   A, B  : addend bits
//   Sum   : A xor B
//   Carry : A and B
module HalfAdder (
  input  logic A,
  input  logic B,
  output logic Sum,
  output logic Carry
);

  assign Sum   = A ^ B;
  assign Carry = A & B;

endmodule

// File: rtl/serial_ha_add_ctrl.sv
// Bit-serial WIDTH-bit adder controller. A single half adder is time-shared:
// each operand bit takes two passes (a+b, then partial+carry), LSB first, so a
// result is produced 2*WIDTH cycles after the command is accepted.
//   clk, rst_n               : clock, asynchronous active-low reset
//   start_valid/start_ready  : command handshake, op_a/op_b/cin sampled on accept
//   res_valid/res_ready      : result handshake, res_valid held until consumed
//   sum, cout                : registered result, stable until the next accept
//   busy                     : high whenever the controller is not idle
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a command; only state in which start_ready is high
// PASS1 | HA(a[0], b[0]) -> partial sum p, first carry c1
// PASS2 | HA(p, carry) -> result bit; shift operands, update carry, count
// DONE  | result presented on sum/cout with res_valid until res_ready
module serial_ha_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int               CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q,   state_d;
  logic [WIDTH-1:0] a_sh_q,    a_sh_d;
  logic [WIDTH-1:0] b_sh_q,    b_sh_d;
  logic [WIDTH-1:0] sum_sh_q,  sum_sh_d;
  logic [WIDTH-1:0] sum_q,     sum_d;
  logic             cout_q,    cout_d;
  logic             carry_q,   carry_d;
  logic             p_q,       p_d;
  logic             c1_q,      c1_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  logic ha_a;
  logic ha_b;
  logic ha_sum;
  logic ha_carry;
  logic accept;

  assign start_ready = (state_q == ST_IDLE) && rst_n;
  assign accept      = start_valid && start_ready;
  assign res_valid   = (state_q == ST_DONE);
  assign busy        = (state_q != ST_IDLE);
  assign sum         = sum_q;
  assign cout        = cout_q;

  HalfAdder u_ha (
    .A     (ha_a),
    .B     (ha_b),
    .Sum   (ha_sum),
    .Carry (ha_carry)
  );

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    sum_sh_d  = sum_sh_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    carry_d   = carry_q;
    p_d       = p_q;
    c1_d      = c1_q;
    bit_cnt_d = bit_cnt_q;
    // HA inputs held at zero outside the two pass states so the cell never toggles idle.
    ha_a      = 1'b0;
    ha_b      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_PASS1;
          a_sh_d    = op_a;
          b_sh_d    = op_b;
          carry_d   = cin;
          sum_sh_d  = '0;
          p_d       = 1'b0;
          c1_d      = 1'b0;
          bit_cnt_d = '0;
        end
      end

      ST_PASS1: begin
        ha_a    = a_sh_q[0];
        ha_b    = b_sh_q[0];
        p_d     = ha_sum;
        c1_d    = ha_carry;
        state_d = ST_PASS2;
      end

      ST_PASS2: begin
        ha_a      = p_q;
        ha_b      = carry_q;
        // Result bits enter at the MSB; after WIDTH shifts bit 0 sits at position 0.
        sum_sh_d  = sum_sh_q >> 1;
        sum_sh_d[WIDTH-1] = ha_sum;
        a_sh_d    = a_sh_q >> 1;
        b_sh_d    = b_sh_q >> 1;
        // c1 and the second-pass carry are mutually exclusive, so OR is the full carry.
        carry_d   = c1_q | ha_carry;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == LAST_BIT) begin
          state_d = ST_DONE;
          sum_d   = sum_sh_d;
          cout_d  = carry_d;
        end else begin
          state_d = ST_PASS1;
        end
      end

      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      sum_sh_q  <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      carry_q   <= 1'b0;
      p_q       <= 1'b0;
      c1_q      <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      sum_sh_q  <= sum_sh_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      carry_q   <= carry_d;
      p_q       <= p_d;
      c1_q      <= c1_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_ha_add_ctrl.sv
// Bench for serial_ha_add_ctrl: directed scenarios on an 8-bit instance, then
// concurrent random traffic on 1-, 8- and 16-bit instances. Expected results
// are queued at command accept and popped when the result handshake occurs.
module tb_serial_ha_add_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] op_a_i [3];
  logic [15:0] op_b_i [3];
  logic        cin_i [3];
  logic        start_valid_i [3];
  logic        res_ready_i [3];
  logic        start_ready_o [3];
  logic        res_valid_o [3];
  logic        cout_o [3];
  logic        busy_o [3];
  logic [15:0] sum_o [3];

  logic [7:0]  sum8;
  logic [0:0]  sum1;
  logic [15:0] sum16;

  assign sum_o[0] = {8'd0, sum8};
  assign sum_o[1] = {15'd0, sum1};
  assign sum_o[2] = sum16;

  logic [16:0] q0 [$];
  logic [16:0] q1 [$];
  logic [16:0] q2 [$];

  serial_ha_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid_i[0]), .start_ready(start_ready_o[0]),
    .op_a(op_a_i[0][7:0]), .op_b(op_b_i[0][7:0]), .cin(cin_i[0]),
    .res_valid(res_valid_o[0]), .res_ready(res_ready_i[0]),
    .sum(sum8), .cout(cout_o[0]), .busy(busy_o[0])
  );

  serial_ha_add_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid_i[1]), .start_ready(start_ready_o[1]),
    .op_a(op_a_i[1][0:0]), .op_b(op_b_i[1][0:0]), .cin(cin_i[1]),
    .res_valid(res_valid_o[1]), .res_ready(res_ready_i[1]),
    .sum(sum1), .cout(cout_o[1]), .busy(busy_o[1])
  );

  serial_ha_add_ctrl #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid_i[2]), .start_ready(start_ready_o[2]),
    .op_a(op_a_i[2]), .op_b(op_b_i[2]), .cin(cin_i[2]),
    .res_valid(res_valid_o[2]), .res_ready(res_ready_i[2]),
    .sum(sum16), .cout(cout_o[2]), .busy(busy_o[2])
  );

  function automatic void sb_push(input int idx, input logic [16:0] v);
    case (idx)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endfunction

  function automatic logic [16:0] sb_pop(input int idx);
    logic [16:0] r;
    r = 'x;
    case (idx)
      0:       if (q0.size() > 0) r = q0.pop_front();
      1:       if (q1.size() > 0) r = q1.pop_front();
      default: if (q2.size() > 0) r = q2.pop_front();
    endcase
    return r;
  endfunction

  // Drives one command on the 8-bit instance starting at a negedge; returns at a
  // negedge with res_valid high (or on timeout). lat = posedges from accept edge.
  task automatic drive_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                          output int lat, output bit tmo);
    int g;
    op_a_i[0] = {8'd0, a};
    op_b_i[0] = {8'd0, b};
    cin_i[0]  = c;
    start_valid_i[0] = 1'b1;
    tmo = 1'b0;
    lat = -1;
    g = 0;
    while (!start_ready_o[0] && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!start_ready_o[0]) begin
      tmo = 1'b1;
      start_valid_i[0] = 1'b0;
      return;
    end
    @(posedge clk);
    sb_push(0, 17'(op_a_i[0]) + 17'(op_b_i[0]) + 17'(cin_i[0]));
    @(negedge clk);
    start_valid_i[0] = 1'b0;
    lat = 0;
    while (!res_valid_o[0] && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!res_valid_o[0]) tmo = 1'b1;
  endtask

  task automatic consume0();
    res_ready_i[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready_i[0] = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (sum_o[0] !== 16'd0) begin n_fail++; $display("FAIL reset_sum got=%h exp=0", sum_o[0]); end
    n_cmp++; if (cout_o[0] !== 1'b0) begin n_fail++; $display("FAIL reset_cout got=%b exp=0", cout_o[0]); end
    n_cmp++; if (res_valid_o[0] !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got=%b exp=0", res_valid_o[0]); end
    n_cmp++; if (busy_o[0] !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_o[0]); end
    n_cmp++; if (start_ready_o[0] !== 1'b0) begin n_fail++; $display("FAIL reset_start_ready got=%b exp=0", start_ready_o[0]); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (start_ready_o[0] !== 1'b1) begin n_fail++; $display("FAIL post_reset_start_ready got=%b exp=1", start_ready_o[0]); end
  endtask

  // Directed add on the 8-bit instance with latency and result checks.
  task automatic test_add(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic [8:0] want);
    int lat;
    bit tmo;
    logic [16:0] exp;
    drive_op(a, b, c, lat, tmo);
    n_cmp++;
    if (tmo || lat !== 16) begin
      n_fail++; $display("FAIL %s_latency got=%0d exp=16 timeout=%0d", name, lat, tmo);
    end
    exp = sb_pop(0);
    n_cmp++;
    if ({cout_o[0], sum_o[0][7:0]} !== exp[8:0]) begin
      n_fail++; $display("FAIL %s_result got=%h exp=%h", name, {cout_o[0], sum_o[0][7:0]}, exp[8:0]);
    end
    n_cmp++;
    if (exp[8:0] !== want) begin
      n_fail++; $display("FAIL %s_model got=%h exp=%h", name, exp[8:0], want);
    end
    consume0();
    n_cmp++;
    if (res_valid_o[0] !== 1'b0) begin
      n_fail++; $display("FAIL %s_res_valid_drop got=%b exp=0", name, res_valid_o[0]);
    end
  endtask

  task automatic test_stall();
    int lat;
    bit tmo;
    logic [16:0] exp1;
    logic [16:0] exp2;
    drive_op(8'h3C, 8'h0F, 1'b1, lat, tmo);
    exp1 = sb_pop(0);
    n_cmp++;
    if (tmo || {cout_o[0], sum_o[0][7:0]} !== exp1[8:0]) begin
      n_fail++; $display("FAIL stall_first_result got=%h exp=%h", {cout_o[0], sum_o[0][7:0]}, exp1[8:0]);
    end
    op_a_i[0] = 16'h0012;
    op_b_i[0] = 16'h0034;
    cin_i[0]  = 1'b0;
    start_valid_i[0] = 1'b1;
    res_ready_i[0]   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (res_valid_o[0] !== 1'b1 || start_ready_o[0] !== 1'b0 ||
          {cout_o[0], sum_o[0][7:0]} !== exp1[8:0]) begin
        n_fail++;
        $display("FAIL stall_hold cyc=%0d got rv=%b sr=%b res=%h exp rv=1 sr=0 res=%h",
                 i, res_valid_o[0], start_ready_o[0], {cout_o[0], sum_o[0][7:0]}, exp1[8:0]);
      end
    end
    res_ready_i[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready_i[0] = 1'b0;
    n_cmp++;
    if (busy_o[0] !== 1'b0 || start_ready_o[0] !== 1'b1 || res_valid_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_idle_gap got busy=%b sr=%b rv=%b exp busy=0 sr=1 rv=0",
               busy_o[0], start_ready_o[0], res_valid_o[0]);
    end
    @(posedge clk);
    sb_push(0, 17'(op_a_i[0]) + 17'(op_b_i[0]) + 17'(cin_i[0]));
    @(negedge clk);
    start_valid_i[0] = 1'b0;
    n_cmp++;
    if (busy_o[0] !== 1'b1) begin
      n_fail++; $display("FAIL stall_second_accept got busy=%b exp=1", busy_o[0]);
    end
    lat = 0;
    while (!res_valid_o[0] && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    n_cmp++;
    if (lat !== 16) begin
      n_fail++; $display("FAIL stall_second_latency got=%0d exp=16", lat);
    end
    exp2 = sb_pop(0);
    n_cmp++;
    if ({cout_o[0], sum_o[0][7:0]} !== exp2[8:0] || exp2[8:0] !== 9'h046) begin
      n_fail++; $display("FAIL stall_second_result got=%h exp=046", {cout_o[0], sum_o[0][7:0]});
    end
    consume0();
  endtask

  task automatic test_reset_mid_op();
    op_a_i[0] = 16'h0099;
    op_b_i[0] = 16'h0011;
    cin_i[0]  = 1'b0;
    start_valid_i[0] = 1'b1;
    n_cmp++;
    if (start_ready_o[0] !== 1'b1) begin
      n_fail++; $display("FAIL midrst_ready got=%b exp=1", start_ready_o[0]);
    end
    @(posedge clk);
    @(negedge clk);
    start_valid_i[0] = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (busy_o[0] !== 1'b1 || sum_o[0] !== 16'h0046) begin
      n_fail++; $display("FAIL midrst_pre got busy=%b sum=%h exp busy=1 sum=0046", busy_o[0], sum_o[0]);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (sum_o[0] !== 16'd0 || cout_o[0] !== 1'b0 || res_valid_o[0] !== 1'b0 ||
        busy_o[0] !== 1'b0 || start_ready_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_clear got sum=%h cout=%b rv=%b busy=%b sr=%b exp all 0",
               sum_o[0], cout_o[0], res_valid_o[0], busy_o[0], start_ready_o[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    begin
      bit seen_rv;
      seen_rv = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (res_valid_o[0] !== 1'b0) seen_rv = 1'b1;
      end
      n_cmp++;
      if (seen_rv) begin
        n_fail++; $display("FAIL midrst_no_result got res_valid=1 exp=0");
      end
    end
    test_add("midrst_next", 8'h12, 8'h34, 1'b0, 9'h046);
  endtask

  task automatic test_random(input int idx, input int w, input int n_ops);
    logic [15:0] mask;
    logic [16:0] exp;
    logic [16:0] got;
    int g;
    bit rr;
    mask = (w == 16) ? 16'hFFFF : 16'((32'd1 << w) - 1);
    for (int k = 0; k < n_ops; k++) begin
      op_a_i[idx] = 16'($urandom) & mask;
      op_b_i[idx] = 16'($urandom) & mask;
      cin_i[idx]  = 1'($urandom_range(0, 1));
      start_valid_i[idx] = 1'b1;
      g = 0;
      while (!start_ready_o[idx] && g < 100) begin
        @(negedge clk);
        g++;
      end
      if (!start_ready_o[idx]) begin
        n_cmp++; n_fail++;
        $display("FAIL rand_w%0d_accept_timeout op=%0d", w, k);
        start_valid_i[idx] = 1'b0;
        return;
      end
      @(posedge clk);
      sb_push(idx, 17'(op_a_i[idx]) + 17'(op_b_i[idx]) + 17'(cin_i[idx]));
      g = 0;
      forever begin
        @(negedge clk);
        n_cmp++;
        if (busy_o[idx] !== !start_ready_o[idx]) begin
          n_fail++; $display("FAIL rand_w%0d_busy got busy=%b sr=%b exp busy=!sr", w, busy_o[idx], start_ready_o[idx]);
        end
        if (res_valid_o[idx] === 1'b1 || g >= 200) break;
        // Noise on the command port while busy must be ignored.
        start_valid_i[idx] = 1'($urandom_range(0, 1));
        op_a_i[idx] = 16'($urandom) & mask;
        op_b_i[idx] = 16'($urandom) & mask;
        g++;
      end
      start_valid_i[idx] = 1'b0;
      if (res_valid_o[idx] !== 1'b1) begin
        n_cmp++; n_fail++;
        $display("FAIL rand_w%0d_result_timeout op=%0d", w, k);
        return;
      end
      g = 0;
      forever begin
        rr = ($urandom_range(0, 3) != 0);
        res_ready_i[idx] = rr;
        if (rr || g >= 50) begin
          exp = sb_pop(idx);
          got = 17'(sum_o[idx]) | (17'(cout_o[idx]) << w);
          n_cmp++;
          if (got !== exp) begin
            n_fail++; $display("FAIL rand_w%0d_result op=%0d got=%h exp=%h", w, k, got, exp);
          end
          res_ready_i[idx] = 1'b1;
          @(posedge clk);
          @(negedge clk);
          res_ready_i[idx] = 1'b0;
          break;
        end
        @(negedge clk);
        g++;
        n_cmp++;
        if (res_valid_o[idx] !== 1'b1) begin
          n_fail++; $display("FAIL rand_w%0d_hold got rv=%b exp=1", w, res_valid_o[idx]);
        end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      op_a_i[i] = '0;
      op_b_i[i] = '0;
      cin_i[i] = 1'b0;
      start_valid_i[i] = 1'b0;
      res_ready_i[i] = 1'b0;
    end
    test_reset();
    test_add("zero",   8'h00, 8'h00, 1'b0, 9'h000);
    test_add("ripple", 8'hFF, 8'h01, 1'b0, 9'h100);
    test_add("7f_p1",  8'h7F, 8'h01, 1'b0, 9'h080);
    test_add("a5_5a",  8'hA5, 8'h5A, 1'b1, 9'h100);
    test_add("12_34",  8'h12, 8'h34, 1'b0, 9'h046);
    test_stall();
    test_reset_mid_op();
    fork
      test_random(1, 1, 1000);
      test_random(0, 8, 1000);
      test_random(2, 16, 1000);
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
